bit_scan_reg: RTL

Parametrised successor to the constant-bus bit-select exercise. The block holds a WIDTH-bit word in a register that resets to a configurable constant. It provides a registered random-access bit read at a run-time index, and serialises the whole word one bit per cycle under a start/ready handshake with abort. It sits between a parallel producer and a 1-bit serial consumer in the course exercise designs.

---
 rtl/bit_scan_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bit_scan_reg.sv
// bit_scan_reg: holds a WIDTH-bit word and offers two ways to read it.
//   - A registered random-access bit read, sel_bit = word[sel_idx].
//   - A one-bit-per-cycle serial scan of the whole word, started by start
//     when ready=1 and ended early by abort.
// Build option: define BIT_SCAN_LSB_FIRST_EN to scan word[0] first.
// The default build scans word[WIDTH-1] first.
//
// Handshake: start is accepted only on an edge where ready=1, meaning the
// block is in IDLE. While ser_valid=1, ser_out carries one bit per cycle
// and there is no backpressure. ser_last marks the final bit. An abort
// sampled at an edge drops ser_valid and raises ready in the next cycle.
module bit_scan_reg #(
    parameter int WIDTH      = 8,
    parameter     RESET_WORD = 8'hF2,
    parameter int IW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             start,
    input  logic             abort,
    input  logic [IW-1:0]    sel_idx,
    output logic             ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic             sel_bit
);

    localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RESET_WORD);
    localparam int               EW       = 1 << IW;
    localparam logic [IW-1:0]    LAST     = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] sh;
    logic [IW-1:0]    cnt;

    // Padding the word to a power-of-two width makes any index past
    // WIDTH-1 read a zero. This removes the need for a range compare.
    logic [EW-1:0]    word_ext;
    logic [WIDTH-1:0] snap;
    logic [IW-1:0]    nxt;
    logic [IW-1:0]    nxt_idx;

    assign word_ext = EW'(word);
    assign snap     = load ? load_word : word;
    assign nxt      = cnt + IW'(1);

`ifdef BIT_SCAN_LSB_FIRST_EN
    localparam logic [IW-1:0] FIRST = '0;
    assign nxt_idx = nxt;
`else
    localparam logic [IW-1:0] FIRST = LAST;
    assign nxt_idx = LAST - nxt;
`endif

    // Word register: a load is honoured only while IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= RST_WORD;
        end else if (state == IDLE && load) begin
            word <= load_word;
        end
    end

    // Random-access read of the live word, one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_bit <= 1'b0;
        end else begin
            sel_bit <= word_ext[sel_idx];
        end
    end

    // Scan FSM.
    // On an accepted start, sh captures a frozen copy of the word, so a
    // load in the same cycle is already included in the copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        sh        <= snap;
                        cnt       <= '0;
                        ready     <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_out   <= snap[FIRST];
                        ser_last  <= 1'b0;
                    end
                end
                SCAN: begin
                    // An abort during the last-bit cycle ends the scan the
                    // same way a normal finish does.
                    if (abort || cnt == LAST) begin
                        state     <= IDLE;
                        ready     <= 1'b1;
                        ser_valid <= 1'b0;
                        ser_out   <= 1'b0;
                        ser_last  <= 1'b0;
                    end else begin
                        cnt      <= nxt;
                        ser_out  <= sh[nxt_idx];
                        ser_last <= (nxt == LAST);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
